// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the memory-port arbiter: FSM encoding, bus width,
// timeout/reset-hold defaults and the opcode returned when a slave never answers.
`ifndef SIZE_OF_THE_BUS
`define SIZE_OF_THE_BUS 32
`endif

package mem_port_arbiter_pkg;

  localparam int BUS_W        = `SIZE_OF_THE_BUS;
  localparam int TIMEOUT_DEF  = 255;
  localparam int RST_HOLD_DEF = 15;
  localparam logic [BUS_W-1:0] ERR_DATA_DEF = BUS_W'(32'h0000_0013);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  // Counter width able to hold max_val, never narrower than 4 bits.
  function automatic int cnt_width(input int max_val);
    int w;
    w = (max_val < 2) ? 1 : $clog2(max_val + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Native memory-protocol channel: request from master, ready/rdata back from slave.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int W = BUS_W
) ();

  logic         valid;
  logic         instr;
  logic [W-1:0] addr;
  logic [W-1:0] wdata;
  logic [3:0]   wstrb;
  logic         ready;
  logic [W-1:0] rdata;

  modport master (
    output valid, instr, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, instr, addr, wdata, wstrb,
    output ready, rdata
  );

endinterface

// File: rtl/mem_port_arbiter_reset_release_seq.sv
// Holds the core in reset for RST_HOLD+1 clock edges after the system reset falls.
module reset_release_seq
  import mem_port_arbiter_pkg::*;
#(
  parameter int RST_HOLD = RST_HOLD_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic core_resetn
);

  localparam int                CNT_W = cnt_width(RST_HOLD);
  localparam logic [CNT_W-1:0] HOLD  = CNT_W'(RST_HOLD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resetn_q, resetn_d;

  always_comb begin
    cnt_d    = cnt_q;
    resetn_d = (cnt_q == HOLD);
    if (cnt_q != HOLD) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      resetn_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      resetn_q <= resetn_d;
    end
  end

  assign core_resetn = resetn_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the core (M0) and the fuzz
// harness (M1); one transaction in flight, response timeout, and core reset release.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int               TIMEOUT  = TIMEOUT_DEF,
  parameter int               RST_HOLD = RST_HOLD_DEF,
  parameter logic [BUS_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    m0,
  mem_port_arbiter_if.slave    m1,
  mem_port_arbiter_if.master   s,
  output logic                 core_resetn,
  output logic                 timeout_pulse,
  output logic [15:0]          timeout_count
);

  localparam int                 WAIT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              s_valid_q, s_valid_d;
  logic              s_instr_q, s_instr_d;
  logic [BUS_W-1:0]  s_addr_q, s_addr_d;
  logic [BUS_W-1:0]  s_wdata_q, s_wdata_d;
  logic [3:0]        s_wstrb_q, s_wstrb_d;
  logic [15:0]       timeout_count_q, timeout_count_d;

  logic             req0, req1, pick_m1;
  logic             granted, done, expired;
  logic [BUS_W-1:0] gnt_rdata;

  reset_release_seq #(
    .RST_HOLD (RST_HOLD)
  ) u_reset_release_seq (
    .clk         (clk),
    .reset       (reset),
    .core_resetn (core_resetn)
  );

  // The core cannot issue requests until it has been let out of reset.
  assign req0    = m0.valid & core_resetn;
  assign req1    = m1.valid;
  assign pick_m1 = req1 & (~req0 | ~last_grant_q);

  assign granted = (state_q != IDLE);
  assign done    = granted & (s.ready | (wait_q == WAIT_MAX));
  assign expired = granted & ~s.ready & (wait_q == WAIT_MAX);

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    wait_d          = wait_q;
    s_valid_d       = s_valid_q;
    s_instr_d       = s_instr_q;
    s_addr_d        = s_addr_q;
    s_wdata_d       = s_wdata_q;
    s_wstrb_d       = s_wstrb_q;
    timeout_count_d = timeout_count_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d      = pick_m1 ? GNT1 : GNT0;
          last_grant_d = pick_m1;
          wait_d       = '0;
          s_valid_d    = 1'b1;
          // Harness accesses are never instruction fetches.
          s_instr_d    = pick_m1 ? (m1.instr & 1'b0) : m0.instr;
          s_addr_d     = pick_m1 ? m1.addr  : m0.addr;
          s_wdata_d    = pick_m1 ? m1.wdata : m0.wdata;
          s_wstrb_d    = pick_m1 ? m1.wstrb : m0.wstrb;
        end
      end
      GNT0, GNT1: begin
        if (done) begin
          state_d   = IDLE;
          s_valid_d = 1'b0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
        if (expired && (timeout_count_q != 16'hFFFF)) begin
          timeout_count_d = timeout_count_q + 16'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        s_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      last_grant_q    <= 1'b1;
      wait_q          <= '0;
      s_valid_q       <= 1'b0;
      s_instr_q       <= 1'b0;
      s_addr_q        <= '0;
      s_wdata_q       <= '0;
      s_wstrb_q       <= '0;
      timeout_count_q <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      wait_q          <= wait_d;
      s_valid_q       <= s_valid_d;
      s_instr_q       <= s_instr_d;
      s_addr_q        <= s_addr_d;
      s_wdata_q       <= s_wdata_d;
      s_wstrb_q       <= s_wstrb_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  // A timed-out fetch hands the core a NOP instead of whatever is on the bus.
  assign gnt_rdata = expired ? ERR_DATA : s.rdata;

  assign m0.ready = (state_q == GNT0) & done;
  assign m1.ready = (state_q == GNT1) & done;
  assign m0.rdata = (state_q == GNT0) ? gnt_rdata : '0;
  assign m1.rdata = (state_q == GNT1) ? gnt_rdata : '0;

  assign s.valid = s_valid_q;
  assign s.instr = s_instr_q;
  assign s.addr  = s_addr_q;
  assign s.wdata = s_wdata_q;
  assign s.wstrb = s_wstrb_q;

  assign timeout_pulse = expired;
  assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level round-robin model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int W = BUS_W;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        core_resetn;
  logic        timeout_pulse;
  logic [15:0] timeout_count;

  int n_checks = 0;
  int n_pass   = 0;

  mem_port_arbiter_if m0_if ();
  mem_port_arbiter_if m1_if ();
  mem_port_arbiter_if s_if ();

  mem_port_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .m0            (m0_if),
    .m1            (m1_if),
    .s             (s_if),
    .core_resetn   (core_resetn),
    .timeout_pulse (timeout_pulse),
    .timeout_count (timeout_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_if.valid = 1'b0; m0_if.instr = 1'b0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.wstrb = '0;
    m1_if.valid = 1'b0; m1_if.instr = 1'b0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.wstrb = '0;
    s_if.ready  = 1'b0; s_if.rdata  = '0;
  endtask

  task automatic reset_and_release();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (RST_HOLD_DEF + 2) tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    m0_if.valid = 1'b1; m0_if.addr = 32'h200;
    #1;
    n_checks++; if ({s_if.valid, s_if.instr, s_if.addr, s_if.wdata, s_if.wstrb} !== '0) $display("FAIL reset_s_bus: got %h required 0", {s_if.valid, s_if.addr}); else n_pass++;
    n_checks++; if ({core_resetn, m0_if.ready, m1_if.ready, timeout_pulse} !== 4'b0) $display("FAIL reset_flags: got %b required 0000", {core_resetn, m0_if.ready, m1_if.ready, timeout_pulse}); else n_pass++;
    n_checks++; if (timeout_count !== 16'd0) $display("FAIL reset_tcount: got %0d required 0", timeout_count); else n_pass++;
    tick();
    reset = 1'b0;
    for (int e = 1; e <= RST_HOLD_DEF + 2; e++) begin
      tick();
      #1;
      n_checks++; if (core_resetn !== (e >= RST_HOLD_DEF + 1)) $display("FAIL rstseq_resetn edge %0d: got %b required %b", e, core_resetn, (e >= RST_HOLD_DEF + 1)); else n_pass++;
      n_checks++; if (s_if.valid !== (e >= RST_HOLD_DEF + 2)) $display("FAIL rstseq_svalid edge %0d: got %b required %b", e, s_if.valid, (e >= RST_HOLD_DEF + 2)); else n_pass++;
    end
    n_checks++; if (s_if.addr !== 32'h200) $display("FAIL rstseq_addr: got %h required 200", s_if.addr); else n_pass++;
    s_if.ready = 1'b1;
    #1;
    n_checks++; if (m0_if.ready !== 1'b1) $display("FAIL rstseq_ready: got %b required 1", m0_if.ready); else n_pass++;
    tick();
    idle_inputs();
    #1;
    n_checks++; if (s_if.valid !== 1'b0) $display("FAIL rstseq_done: got %b required 0", s_if.valid); else n_pass++;
  endtask

  task automatic test_single_read();
    m0_if.valid = 1'b1; m0_if.instr = 1'b1; m0_if.addr = 32'h100; m0_if.wstrb = 4'h0;
    tick(); #1;
    n_checks++; if ({s_if.valid, s_if.instr, s_if.addr, s_if.wstrb} !== {1'b1, 1'b1, 32'h100, 4'h0}) $display("FAIL read_req: got v%b i%b a%h s%h required v1 i1 a100 s0", s_if.valid, s_if.instr, s_if.addr, s_if.wstrb); else n_pass++;
    n_checks++; if (m0_if.ready !== 1'b0) $display("FAIL read_early0: got %b required 0", m0_if.ready); else n_pass++;
    tick(); #1;
    n_checks++; if (m0_if.ready !== 1'b0) $display("FAIL read_early1: got %b required 0", m0_if.ready); else n_pass++;
    tick();
    s_if.ready = 1'b1; s_if.rdata = 32'hDEADBEEF;
    #1;
    n_checks++; if ({m0_if.ready, m0_if.rdata} !== {1'b1, 32'hDEADBEEF}) $display("FAIL read_resp: got r%b d%h required r1 dDEADBEEF", m0_if.ready, m0_if.rdata); else n_pass++;
    n_checks++; if ({m1_if.ready, m1_if.rdata} !== {1'b0, 32'h0}) $display("FAIL read_m1_quiet: got r%b d%h required r0 d0", m1_if.ready, m1_if.rdata); else n_pass++;
    tick();
    idle_inputs();
    #1;
    n_checks++; if ({s_if.valid, m0_if.ready} !== 2'b00) $display("FAIL read_end: got %b required 00", {s_if.valid, m0_if.ready}); else n_pass++;
  endtask

  task automatic test_tie_alternate();
    logic exp_m1;
    reset_and_release();
    m0_if.valid = 1'b1; m0_if.addr = 32'hA00;
    m1_if.valid = 1'b1; m1_if.addr = 32'hB00;
    s_if.ready  = 1'b1; s_if.rdata = 32'h1111_2222;
    for (int k = 0; k < 4; k++) begin
      exp_m1 = (k % 2 == 1);
      tick(); #1;
      n_checks++; if ({s_if.valid, s_if.addr} !== {1'b1, exp_m1 ? 32'hB00 : 32'hA00}) $display("FAIL tie_grant %0d: got v%b a%h required master %0d", k, s_if.valid, s_if.addr, exp_m1); else n_pass++;
      n_checks++; if ({m0_if.ready, m1_if.ready} !== {~exp_m1, exp_m1}) $display("FAIL tie_ready %0d: got %b required %b", k, {m0_if.ready, m1_if.ready}, {~exp_m1, exp_m1}); else n_pass++;
      tick(); #1;
      n_checks++; if (s_if.valid !== 1'b0) $display("FAIL tie_gap %0d: got %b required 0", k, s_if.valid); else n_pass++;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_m1_write();
    m1_if.valid = 1'b1; m1_if.instr = 1'b1; m1_if.addr = 32'h40; m1_if.wdata = 32'h12345678; m1_if.wstrb = 4'hF;
    tick(); #1;
    n_checks++; if ({s_if.valid, s_if.instr, s_if.addr, s_if.wdata, s_if.wstrb} !== {1'b1, 1'b0, 32'h40, 32'h12345678, 4'hF}) $display("FAIL write_fwd: got v%b i%b a%h d%h s%h required v1 i0 a40 d12345678 sF", s_if.valid, s_if.instr, s_if.addr, s_if.wdata, s_if.wstrb); else n_pass++;
    n_checks++; if (m1_if.ready !== 1'b0) $display("FAIL write_early: got %b required 0", m1_if.ready); else n_pass++;
    tick();
    s_if.ready = 1'b1;
    #1;
    n_checks++; if ({m1_if.ready, m0_if.ready} !== 2'b10) $display("FAIL write_ready: got %b required 10", {m1_if.ready, m0_if.ready}); else n_pass++;
    tick();
    idle_inputs();
    #1;
  endtask

  task automatic test_timeout();
    int first_ready = -1;
    int pulses      = 0;
    m0_if.valid = 1'b1; m0_if.instr = 1'b1; m0_if.addr = 32'h300;
    s_if.rdata  = 32'hCAFEF00D;
    tick(); #1;
    for (int i = 0; i <= TIMEOUT_DEF; i++) begin
      if (i > 0) begin
        tick(); #1;
      end
      if (m0_if.ready === 1'b1 && first_ready < 0) first_ready = i;
      if (timeout_pulse === 1'b1) pulses++;
      if (i == TIMEOUT_DEF) begin
        n_checks++; if (m0_if.rdata !== ERR_DATA_DEF) $display("FAIL to_rdata: got %h required %h", m0_if.rdata, ERR_DATA_DEF); else n_pass++;
      end
    end
    n_checks++; if (first_ready != TIMEOUT_DEF) $display("FAIL to_ready_at: got %0d required %0d", first_ready, TIMEOUT_DEF); else n_pass++;
    n_checks++; if (pulses != 1) $display("FAIL to_pulses: got %0d required 1", pulses); else n_pass++;
    tick();
    m0_if.valid = 1'b0;
    #1;
    n_checks++; if ({s_if.valid, timeout_count} !== {1'b0, 16'd1}) $display("FAIL to_after: got v%b c%0d required v0 c1", s_if.valid, timeout_count); else n_pass++;
    s_if.ready = 1'b1;
    tick(); tick(); #1;
    n_checks++; if ({s_if.valid, m0_if.ready, m1_if.ready, timeout_count} !== {3'b000, 16'd1}) $display("FAIL to_late_ready: got %b c%0d required 000 c1", {s_if.valid, m0_if.ready, m1_if.ready}, timeout_count); else n_pass++;
    // Response arriving on the very cycle the wait limit is reached.
    s_if.ready = 1'b0;
    m0_if.valid = 1'b1; m0_if.addr = 32'h304;
    tick();
    repeat (TIMEOUT_DEF) tick();
    s_if.ready = 1'b1; s_if.rdata = 32'h0000_600D;
    #1;
    n_checks++; if ({m0_if.ready, m0_if.rdata, timeout_pulse} !== {1'b1, 32'h600D, 1'b0}) $display("FAIL to_race: got r%b d%h p%b required r1 d600D p0", m0_if.ready, m0_if.rdata, timeout_pulse); else n_pass++;
    tick();
    idle_inputs();
    #1;
    n_checks++; if (timeout_count !== 16'd1) $display("FAIL to_race_count: got %0d required 1", timeout_count); else n_pass++;
  endtask

  task automatic test_reset_mid_txn();
    m1_if.valid = 1'b1; m1_if.addr = 32'h80; m1_if.wdata = 32'h55AA55AA; m1_if.wstrb = 4'h3;
    tick(); #1;
    n_checks++; if (s_if.valid !== 1'b1) $display("FAIL mid_granted: got %b required 1", s_if.valid); else n_pass++;
    s_if.ready = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    n_checks++; if ({s_if.valid, m1_if.ready, core_resetn} !== 3'b000) $display("FAIL mid_reset: got %b required 000", {s_if.valid, m1_if.ready, core_resetn}); else n_pass++;
    idle_inputs();
    tick();
    reset = 1'b0;
    repeat (RST_HOLD_DEF + 2) tick();
    m0_if.valid = 1'b1; m0_if.addr = 32'hC00;
    m1_if.valid = 1'b1; m1_if.addr = 32'hD00;
    tick(); #1;
    n_checks++; if ({s_if.valid, s_if.addr} !== {1'b1, 32'hC00}) $display("FAIL mid_tie: got v%b a%h required v1 aC00", s_if.valid, s_if.addr); else n_pass++;
    s_if.ready = 1'b1;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    logic         r_valid [2];
    logic         r_instr [2];
    logic [W-1:0] r_addr  [2];
    logic [W-1:0] r_wdata [2];
    logic [3:0]   r_wstrb [2];
    logic [W+W+4:0] e_req;
    logic [W-1:0] drv_rdata;
    logic         rdy [2];
    logic [W-1:0] rd  [2];
    bit           busy  = 0;
    int           owner = 0;
    int           rem   = 0;
    int           last  = 1;
    int           g;
    reset_and_release();
    for (int m = 0; m < 2; m++) begin
      r_valid[m] = 1'b0; r_instr[m] = 1'b0; r_addr[m] = '0; r_wdata[m] = '0; r_wstrb[m] = '0;
    end
    e_req = '0;
    for (int c = 0; c < 600; c++) begin
      m0_if.valid = r_valid[0]; m0_if.instr = r_instr[0]; m0_if.addr = r_addr[0]; m0_if.wdata = r_wdata[0]; m0_if.wstrb = r_wstrb[0];
      m1_if.valid = r_valid[1]; m1_if.instr = r_instr[1]; m1_if.addr = r_addr[1]; m1_if.wdata = r_wdata[1]; m1_if.wstrb = r_wstrb[1];
      s_if.ready  = busy ? (rem == 0) : ($urandom_range(0, 3) == 0);
      drv_rdata   = $urandom;
      s_if.rdata  = drv_rdata;
      #1;
      rdy[0] = m0_if.ready; rdy[1] = m1_if.ready;
      rd[0]  = m0_if.rdata; rd[1]  = m1_if.rdata;
      if (busy) begin
        n_checks++; if ({s_if.valid, s_if.instr, s_if.addr, s_if.wdata, s_if.wstrb} !== {1'b1, e_req}) $display("FAIL rnd_req c%0d: got a%h d%h required a%h d%h", c, s_if.addr, s_if.wdata, e_req[W+W+3:W+4], e_req[W+3:4]); else n_pass++;
        n_checks++; if (rdy[owner] !== (rem == 0) || rdy[1-owner] !== 1'b0) $display("FAIL rnd_ready c%0d: got m0 %b m1 %b owner %0d rem %0d", c, rdy[0], rdy[1], owner, rem); else n_pass++;
        n_checks++; if (rd[owner] !== drv_rdata || rd[1-owner] !== '0) $display("FAIL rnd_rdata c%0d: got %h/%h required %h on m%0d", c, rd[0], rd[1], drv_rdata, owner); else n_pass++;
      end else begin
        n_checks++; if ({s_if.valid, rdy[0], rdy[1]} !== 3'b000) $display("FAIL rnd_idle c%0d: got %b required 000", c, {s_if.valid, rdy[0], rdy[1]}); else n_pass++;
        n_checks++; if (rd[0] !== '0 || rd[1] !== '0) $display("FAIL rnd_idle_rdata c%0d: got %h/%h required 0", c, rd[0], rd[1]); else n_pass++;
      end
      if (busy) begin
        if (rem == 0) begin
          busy = 0;
          r_valid[owner] = 1'b0;
        end else begin
          rem--;
          if ($urandom_range(0, 7) == 0) r_valid[owner] = 1'b0;
        end
      end else begin
        g = -1;
        if (r_valid[0] && r_valid[1]) g = 1 - last;
        else if (r_valid[0]) g = 0;
        else if (r_valid[1]) g = 1;
        if (g >= 0) begin
          busy  = 1;
          owner = g;
          last  = g;
          rem   = $urandom_range(0, 3);
          e_req = {(g == 0) ? r_instr[0] : 1'b0, r_addr[g], r_wdata[g], r_wstrb[g]};
        end
      end
      for (int m = 0; m < 2; m++) begin
        if (!r_valid[m] && !(busy && owner == m) && $urandom_range(0, 1) == 1) begin
          r_valid[m] = 1'b1;
          r_instr[m] = 1'($urandom_range(0, 1));
          r_addr[m]  = $urandom;
          r_wdata[m] = $urandom;
          r_wstrb[m] = 4'($urandom_range(0, 15));
        end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_tie_alternate();
    test_m1_write();
    test_timeout();
    test_reset_mid_txn();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single native-protocol port of memory_modelling between two requesters.
  - M0 is the picorv32 core.
  - M1 is the fuzz harness (pre-load, mutation and readback).
- Round-robin arbitration, one outstanding transaction at a time, and a per-transaction response timeout.
- Also sequences the core's reset release, so picorv32core instantiates this block instead of its ad-hoc rst_counter.

Parameters:
- BUS_W, `SIZE_OF_THE_BUS (32), address/data width.
- TIMEOUT, 255, maximum cycles a granted transaction waits for s_ready.
- RST_HOLD, 15, cycles core_resetn stays low after reset deasserts.
- ERR_DATA, 32'h0000_0013, rdata returned on timeout (RV32 NOP).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- m0_valid/m0_instr  in  1/1  core request, instruction-fetch flag.
- m0_addr/m0_wdata  in  BUS_W/BUS_W  core address, write data.
- m0_wstrb  in  4  core byte strobes (0 = read).
- m0_ready  out  1  core transaction complete.
- m0_rdata  out  BUS_W  core read data.
- m1_valid/m1_addr/m1_wdata/m1_wstrb  in  1/BUS_W/BUS_W/4  harness request.
- m1_ready  out  1  harness complete.
- m1_rdata  out  BUS_W  harness read data.
- s_valid/s_instr  out  1/1  request to memory_modelling.
- s_addr/s_wdata/s_wstrb  out  BUS_W/BUS_W/4  forwarded request.
- s_ready  in  1  memory response.
- s_rdata  in  BUS_W  memory read data.
- core_resetn  out  1  active-low reset to picorv32.
- timeout_pulse  out  1  one-cycle flag when a transaction times out.
- timeout_count  out  16  saturating count of timeouts.

Behaviour:
Reset (asynchronous, immediate, including mid-transaction):
- Outputs: state=IDLE, s_valid=0, s_instr=0, s_addr/s_wdata/s_wstrb=0, m*_ready=0, core_resetn=0, timeout_pulse=0, timeout_count=0.
- Internal: last_grant=1, so M0 wins the first tie.

Reset sequencer:
- 4-bit-or-wider counter increments every cycle after reset and saturates at RST_HOLD.
- core_resetn goes high on the cycle after the counter reaches RST_HOLD, i.e. RST_HOLD+1 edges after reset falls.
- While core_resetn=0, m0_valid is ignored.

FSM states: IDLE, GNT0, GNT1.
- IDLE:
  - Sample requests.
  - Only one requester valid: grant it.
  - Both valid: grant the master that is not last_grant.
  - On grant, latch that master's request into the s_* registers, set s_valid=1 and s_instr (M1 forces 0), update last_grant, and go to GNTx.
  - Latency: request at edge T gives s_valid=1 at T+1.
- GNTx, s_ready=1:
  - mx_ready=1 combinationally that cycle; mx_rdata=s_rdata.
  - Next edge: s_valid=0, return to IDLE.
  - Earliest next grant follows one cycle later (minimum one idle cycle between transactions).
- GNTx, s_ready=0:
  - Wait counter increments.
  - When it equals TIMEOUT: mx_ready=1, mx_rdata=ERR_DATA, timeout_pulse=1 that cycle, timeout_count+=1 (saturates at 16'hFFFF), s_valid drops next edge, return to IDLE.
- Simultaneous s_ready and wait counter = TIMEOUT: s_ready wins, no timeout recorded.

Handshake rules:
- Masters hold valid/addr/wdata/wstrb stable until ready.
- The ungranted master's ready is always 0.
- Ungranted rdata reads 0.
- s_ready arriving in IDLE (late response after a timeout) is ignored.
- A master dropping valid while granted does not abort; the transaction completes to the slave.
- Wait counter clears on every grant.

Decomposition:
- Shared package (model_parameters): state encoding IDLE/GNT0/GNT1, ERR_DATA default, TIMEOUT/RST_HOLD defaults, reuse of `SIZE_OF_THE_BUS.
- One natural sub-module: reset_release_seq (counter plus core_resetn); the arbiter FSM stays in the top.

Test Plan:
- Reset sequencing: deassert reset at cycle 0 → core_resetn=0 through edge 15, =1 from edge 16. m0_valid held high during the hold → no s_valid until core_resetn=1.
- Single M0 read of addr 0x100, slave ready 2 cycles after s_valid with s_rdata=0xDEADBEEF → s_addr=0x100, s_instr=m0_instr, m0_ready pulse with rdata 0xDEADBEEF, m1_ready stays 0.
- M0 and M1 request the same cycle after reset → M0 granted first; M1 granted after M0 completes plus one idle cycle. Both held continuously → grants alternate 0,1,0,1.
- M1 write 0x12345678 to 0x40 with wstrb=4'hF → s_wdata/s_wstrb forwarded exactly, s_instr=0, m1_ready on s_ready.
- Slave never responds to an M0 fetch → m0_ready at wait count 255 with rdata=0x00000013, timeout_pulse one cycle, timeout_count=1. Late s_ready afterwards is ignored.
- Assert reset while in GNT1 → s_valid and m1_ready drop immediately, core_resetn=0. After release, M0 wins a tie (last_grant=1).
